// File: rtl/rv32_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rv32_wb_arbiter
//
// Merges writeback traffic onto the register file's single synchronous write
// port. Single-cycle ALU results normally win; long-latency LSU load results
// wait in a small FIFO. A starvation counter forces the FIFO head through after
// STARVE_MAX consecutive deferred cycles, asserting alu_stall so the core holds
// its ALU writeback for that cycle.
//
// Optional feature macro: WB_BYPASS_EN (adds a forwarding tap on the registered
// write port for the two source operands of the decode stage).
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   alu_wb_*        ALU result: valid / rd / data, no backpressure
//   lsu_wb_*        LSU result: valid / ready / rd / data
//   alu_stall       core must hold its ALU writeback this cycle
//   rf_wr_en        registered register-file write enable
//   rf_rd_addr      registered register-file write address
//   rf_rd_data      registered register-file write data
//   fifo_count      number of buffered LSU entries
//   err_drop        sticky: an ALU result arrived while alu_stall was high
//   byp_*           (WB_BYPASS_EN only) operand address compare against the
//                   registered write port, plus the forwarded data
// -----------------------------------------------------------------------------
module rv32_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               alu_wb_valid,
   input  logic [REG_ADDR_W-1:0]              alu_wb_rd,
   input  logic [XLEN-1:0]                    alu_wb_data,
   input  logic                               lsu_wb_valid,
   output logic                               lsu_wb_ready,
   input  logic [REG_ADDR_W-1:0]              lsu_wb_rd,
   input  logic [XLEN-1:0]                    lsu_wb_data,
   output logic                               alu_stall,
   output logic                               rf_wr_en,
   output logic [REG_ADDR_W-1:0]              rf_rd_addr,
   output logic [XLEN-1:0]                    rf_rd_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
`ifdef WB_BYPASS_EN
   input  logic [REG_ADDR_W-1:0]              byp_rs1_addr,
   input  logic [REG_ADDR_W-1:0]              byp_rs2_addr,
   output logic                               byp_rs1_hit,
   output logic                               byp_rs2_hit,
   output logic [XLEN-1:0]                    byp_data,
`endif
   output logic                               err_drop
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

   // Source of this cycle's register-file write, in priority order.
   typedef enum logic [1:0] {
      WB_NONE,
      WB_FORCED,   // starvation limit reached: FIFO head wins over ALU
      WB_ALU,
      WB_FIFO
   } wb_src_e;

   logic [REG_ADDR_W-1:0] mem_rd   [FIFO_DEPTH];
   logic [XLEN-1:0]       mem_data [FIFO_DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [STV_W-1:0]      starve_q, starve_d;
   logic                  rf_wr_en_q, rf_wr_en_d;
   logic [REG_ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
   logic [XLEN-1:0]       rf_rd_data_q, rf_rd_data_d;
   logic                  err_drop_q, err_drop_d;

   logic    fifo_empty;
   logic    alu_req;
   logic    push;
   logic    pop;
   wb_src_e wb_src;

   assign fifo_empty   = (count_q == '0);
   // Ready comes from the registered count, so a pop while full frees the slot
   // only in the following cycle.
   assign lsu_wb_ready = !rst && (count_q != CNT_FULL);
   assign alu_stall    = (starve_q == STV_SAT);
   // Writes to x0 are architectural no-ops: never arbitrate or buffer them.
   assign alu_req      = alu_wb_valid && (alu_wb_rd != '0);
   assign push         = lsu_wb_valid && lsu_wb_ready && (lsu_wb_rd != '0);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      wb_src = WB_NONE;
      if (alu_stall && !fifo_empty) begin
         wb_src = WB_FORCED;
      end else if (alu_req) begin
         wb_src = WB_ALU;
      end else if (!fifo_empty) begin
         wb_src = WB_FIFO;
      end
   end

   assign pop = (wb_src == WB_FORCED) || (wb_src == WB_FIFO);

   always_comb begin
      rf_wr_en_d   = 1'b0;
      rf_rd_addr_d = rf_rd_addr_q;
      rf_rd_data_d = rf_rd_data_q;
      err_drop_d   = err_drop_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      starve_d     = starve_q;

      case (wb_src)
         WB_FORCED, WB_FIFO: begin
            rf_wr_en_d   = 1'b1;
            rf_rd_addr_d = mem_rd[rd_ptr_q];
            rf_rd_data_d = mem_data[rd_ptr_q];
         end
         WB_ALU: begin
            rf_wr_en_d   = 1'b1;
            rf_rd_addr_d = alu_wb_rd;
            rf_rd_data_d = alu_wb_data;
         end
         default: ;
      endcase

      // The core ignored alu_stall: its result is lost, flag it until reset.
      if ((wb_src == WB_FORCED) && alu_req) begin
         err_drop_d = 1'b1;
      end

      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q != STV_SAT) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_q     <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_addr_q <= '0;
         rf_rd_data_q <= '0;
         err_drop_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_q     <= starve_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_rd_addr_q <= rf_rd_addr_d;
         rf_rd_data_q <= rf_rd_data_d;
         err_drop_q   <= err_drop_d;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; count_q gates every read, so stale contents are never used.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr_q]   <= lsu_wb_rd;
         mem_data[wr_ptr_q] <= lsu_wb_data;
      end
   end

   assign rf_wr_en   = rf_wr_en_q;
   assign rf_rd_addr = rf_rd_addr_q;
   assign rf_rd_data = rf_rd_data_q;
   assign fifo_count = count_q;
   assign err_drop   = err_drop_q;

`ifdef WB_BYPASS_EN
   // Forward the value being written this cycle; x0 never hits.
   assign byp_rs1_hit = rf_wr_en_q && (rf_rd_addr_q == byp_rs1_addr) && (byp_rs1_addr != '0);
   assign byp_rs2_hit = rf_wr_en_q && (rf_rd_addr_q == byp_rs2_addr) && (byp_rs2_addr != '0);
   assign byp_data    = rf_rd_data_q;
`endif

endmodule
